// File: rtl/dispense_if.sv
// Controller-side bundle for dispense_driver: vend/change events in, actuator drives and status out.
interface dispense_if #(
    parameter int QDEPTH = 4
);
    localparam int PW = $clog2(QDEPTH) + 1;

    logic          vend;
    logic [1:0]    change;
    logic          solenoid;
    logic          eject;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;
    logic          illegal;

    modport master (
        output vend, change,
        input  solenoid, eject, busy, pending, overflow, illegal
    );

    modport slave (
        input  vend, change,
        output solenoid, eject, busy, pending, overflow, illegal
    );
endinterface

// File: rtl/dispense_driver.sv
// Queues vend/refund events from the coin controller and replays them as timed
// solenoid and coin-ejector pulses with guaranteed low gaps between pulses.
module dispense_driver #(
    parameter int VEND_CYCLES  = 8,
    parameter int EJECT_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int QDEPTH       = 4
) (
    input  logic      clk,
    input  logic      rst,
    dispense_if.slave bus
);
    localparam int PW   = $clog2(QDEPTH) + 1;
    localparam int AW   = $clog2(QDEPTH);
    localparam int MAXC = (VEND_CYCLES > EJECT_CYCLES)
                          ? ((VEND_CYCLES > GAP_CYCLES) ? VEND_CYCLES : GAP_CYCLES)
                          : ((EJECT_CYCLES > GAP_CYCLES) ? EJECT_CYCLES : GAP_CYCLES);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] VEND_LAST  = CW'(VEND_CYCLES - 1);
    localparam logic [CW-1:0] EJECT_LAST = CW'(EJECT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] FULL_CNT   = PW'(QDEPTH);

    typedef enum logic [2:0] {IDLE, VEND, VGAP, EJECT, EGAP} state_t;

    // S0: input capture, isolates the controller's combinational outputs
    logic          vend_q;
    logic [1:0]    chg_q;

    logic [2:0]    fifo_q [QDEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    coins_q, coins_d;

    logic          solenoid_q, eject_q, busy_q, ovf_q, ill_q;

    logic [1:0]    chg_eff;
    logic          push, pop, push_ok, drop;
    logic [PW-1:0] pending;
    logic          empty, full;
    logic [2:0]    head;

    // Illegal refund code carries no coins but a vend in the same sample still counts
    assign chg_eff = (chg_q == 2'b11) ? 2'b00 : chg_q;
    assign push    = vend_q | (chg_eff != 2'b00);
    assign pending = wr_q - rd_q;
    assign empty   = (pending == '0);
    assign full    = (pending == FULL_CNT);
    assign head    = fifo_q[rd_q[AW-1:0]];
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign wr_d    = push_ok ? wr_q + PW'(1) : wr_q;
    assign rd_d    = pop ? rd_q + PW'(1) : rd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        coins_d = coins_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    coins_d = head[1:0];
                    if (head[2])
                        state_d = VEND;
                    else if (head[1:0] != 2'b00)
                        state_d = EJECT;
                end
            end
            VEND: begin
                if (cnt_q == VEND_LAST) begin
                    state_d = VGAP;
                    cnt_d   = '0;
                end
            end
            EJECT: begin
                if (cnt_q == EJECT_LAST) begin
                    state_d = EGAP;
                    cnt_d   = '0;
                    coins_d = coins_q - 2'd1;
                end
            end
            VGAP, EGAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = (coins_q != 2'b00) ? EJECT : IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vend_q     <= 1'b0;
            chg_q      <= 2'b00;
            wr_q       <= '0;
            rd_q       <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            coins_q    <= 2'b00;
            solenoid_q <= 1'b0;
            eject_q    <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            vend_q     <= bus.vend;
            chg_q      <= bus.change;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            coins_q    <= coins_d;
            // Drives follow the next state so the pulse is aligned with the state itself
            solenoid_q <= (state_d == VEND);
            eject_q    <= (state_d == EJECT);
            busy_q     <= (state_q != IDLE) || (pending != '0);
            ovf_q      <= ovf_q | drop;
            ill_q      <= ill_q | (chg_q == 2'b11);
        end
    end

    // FIFO storage is data only; emptiness is defined by the pointers
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_q[wr_q[AW-1:0]] <= {vend_q, chg_eff};
    end

    assign bus.solenoid = solenoid_q;
    assign bus.eject    = eject_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pending;
    assign bus.overflow = ovf_q;
    assign bus.illegal  = ill_q;
endmodule

// File: tb/tb_dispense_driver.sv
// Directed bench for dispense_driver: per-event pulse tables plus reset, overflow and full-boundary sequences.
module tb_dispense_driver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dispense_if #(.QDEPTH(4)) bus ();

    dispense_driver #(
        .VEND_CYCLES (8),
        .EJECT_CYCLES(4),
        .GAP_CYCLES  (2),
        .QDEPTH      (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int cyc, sol_rise, sol_hi, ej_rise, ej_hi, first_sol, first_ej, last_act, overlap, max_pend;
    logic prev_sol, prev_ej;

    typedef struct {
        logic       v;
        logic [1:0] ch;
        int         sol_p;
        int         sol_h;
        int         ej_p;
        int         ej_h;
        int         f_sol;
        int         f_ej;
        int         last;
        int         ill;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        cyc = 0; sol_rise = 0; sol_hi = 0; ej_rise = 0; ej_hi = 0;
        first_sol = -1; first_ej = -1; last_act = -1; overlap = 0; max_pend = 0;
        prev_sol = 1'b0; prev_ej = 1'b0;
    endtask

    // One clock; sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.solenoid === 1'b1) begin
            sol_hi++;
            last_act = cyc;
            if (!prev_sol) begin
                sol_rise++;
                if (first_sol < 0) first_sol = cyc;
            end
        end
        if (bus.eject === 1'b1) begin
            ej_hi++;
            last_act = cyc;
            if (!prev_ej) begin
                ej_rise++;
                if (first_ej < 0) first_ej = cyc;
            end
        end
        if (bus.solenoid === 1'b1 && bus.eject === 1'b1) overlap++;
        if (int'(bus.pending) > max_pend) max_pend = int'(bus.pending);
        prev_sol = bus.solenoid;
        prev_ej  = bus.eject;
        cyc++;
    endtask

    task automatic do_reset();
        bus.vend   = 1'b0;
        bus.change = 2'b00;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clr_mon();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v     ch     sp sh ep eh fs  fe  last ill
        vecs[0] = '{1'b1, 2'b00, 1, 8, 0, 0, 2, -1,  9, 0};
        vecs[1] = '{1'b1, 2'b01, 1, 8, 1, 4, 2, 12, 15, 0};
        vecs[2] = '{1'b0, 2'b10, 0, 0, 2, 8, -1, 2, 11, 0};
        vecs[3] = '{1'b0, 2'b01, 0, 0, 1, 4, -1, 2,  5, 0};
        vecs[4] = '{1'b1, 2'b11, 1, 8, 0, 0, 2, -1,  9, 1};
        vecs[5] = '{1'b0, 2'b11, 0, 0, 0, 0, -1, -1, -1, 1};
        vecs[6] = '{1'b1, 2'b10, 1, 8, 2, 8, 2, 12, 21, 0};

        bus.vend   = 1'b0;
        bus.change = 2'b00;
        clr_mon();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_solenoid", bus.solenoid, 0);
        chk("rst_eject",    bus.eject,    0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_pending",  bus.pending,  0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_illegal",  bus.illegal,  0);

        // Single-event table
        for (int i = 0; i < 7; i++) begin
            do_reset();
            @(negedge clk);
            bus.vend   = vecs[i].v;
            bus.change = vecs[i].ch;
            for (int c = 0; c < 40; c++) begin
                step();
                if (c == 0) begin
                    bus.vend   = 1'b0;
                    bus.change = 2'b00;
                end
            end
            chk($sformatf("v%0d_sol_pulses", i), sol_rise,  vecs[i].sol_p);
            chk($sformatf("v%0d_sol_high",   i), sol_hi,    vecs[i].sol_h);
            chk($sformatf("v%0d_ej_pulses",  i), ej_rise,   vecs[i].ej_p);
            chk($sformatf("v%0d_ej_high",    i), ej_hi,     vecs[i].ej_h);
            chk($sformatf("v%0d_first_sol",  i), first_sol, vecs[i].f_sol);
            chk($sformatf("v%0d_first_ej",   i), first_ej,  vecs[i].f_ej);
            chk($sformatf("v%0d_last_act",   i), last_act,  vecs[i].last);
            chk($sformatf("v%0d_illegal",    i), bus.illegal, vecs[i].ill);
            chk($sformatf("v%0d_overlap",    i), overlap,   0);
            chk($sformatf("v%0d_overflow",   i), bus.overflow, 0);
            chk($sformatf("v%0d_busy_end",   i), bus.busy,  0);
            chk($sformatf("v%0d_pend_end",   i), bus.pending, 0);
        end

        // Reset in the middle of a solenoid pulse
        do_reset();
        @(negedge clk);
        bus.vend = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) bus.vend = 1'b0;
        end
        chk("mid_sol_before", bus.solenoid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_sol_async",  bus.solenoid, 0);
        chk("mid_pend_async", bus.pending,  0);
        chk("mid_busy_async", bus.busy,     0);
        @(negedge clk);
        rst = 1'b1;
        clr_mon();
        for (int c = 0; c < 30; c++) step();
        chk("mid_no_pulses", sol_hi + ej_hi, 0);
        chk("mid_busy_end",  bus.busy,    0);
        chk("mid_pend_end",  bus.pending, 0);

        // Six back-to-back vends into a 4-deep queue
        do_reset();
        @(negedge clk);
        bus.vend = 1'b1;
        for (int c = 0; c < 80; c++) begin
            step();
            bus.vend = (c < 5);
            if (c == 5) chk("ovf_before_drop", bus.overflow, 0);
            if (c == 6) chk("ovf_at_drop",     bus.overflow, 1);
        end
        chk("ovf_sol_pulses", sol_rise,     5);
        chk("ovf_sol_high",   sol_hi,       40);
        chk("ovf_max_pend",   max_pend,     4);
        chk("ovf_sticky",     bus.overflow, 1);
        chk("ovf_busy_end",   bus.busy,     0);

        // Full queue while the FSM pops on the same edge a new event is pushed
        do_reset();
        @(negedge clk);
        bus.vend = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            bus.vend = (c < 4) || (c == 11);
            if (c == 5)  chk("bnd_full",       bus.pending,  4);
            if (c == 9)  chk("bnd_sol_last",   bus.solenoid, 1);
            if (c == 10) chk("bnd_sol_gap",    bus.solenoid, 0);
            if (c == 12) chk("bnd_pend_pre",   bus.pending,  4);
            if (c == 13) begin
                chk("bnd_pend_same",  bus.pending,  4);
                chk("bnd_no_ovf",     bus.overflow, 0);
                chk("bnd_sol_next",   bus.solenoid, 1);
            end
        end
        for (int c = 0; c < 80; c++) step();
        chk("bnd_sol_pulses", sol_rise,     6);
        chk("bnd_ovf_end",    bus.overflow, 0);
        chk("bnd_busy_end",   bus.busy,     0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
